// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target controller slice.
// Mode 0 (CPOL=0, CPHA=0) is the only mode the controller implements.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_tgt_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin plus a third flop
// used to detect rising and falling edges of the synchronized level.
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_target_ctrl.sv
// SPI target (mode 0) word engine: shifts tx FIFO words out on miso and
// assembles mosi words into the rx FIFO, with frame and error flags.
module spi_target_ctrl
  import spi_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               BLOCK_WORDS = 4,
  parameter logic [DATA_W-1:0] FILL       = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spe,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_empty,
  output logic              tx_rd_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_wr_en,
  input  logic              rx_full,
  output logic              spif,
  output logic              overrun,
  output logic              underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int WC_W  = $clog2(BLOCK_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [WC_W-1:0]  WORDS_MAX = WC_W'(BLOCK_WORDS);

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic w_sample, w_shift;
  logic r_mosi_meta, r_mosi_sync;

  spi_tgt_state_t      r_state;
  logic [DATA_W-1:0]   r_tx_sh, r_rx_sh, r_rx_data;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WC_W-1:0]     r_word_cnt;
  logic                r_miso, r_tx_rd_en, r_rx_wr_en;
  logic                r_overrun, r_underrun, r_end_pend;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (ss_n),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  // mosi shares the sclk synchronizer depth so it is aligned with the sample edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_sample = (SPI_CPOL == SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_shift  = (SPI_CPOL == SPI_CPHA) ? w_sclk_fall : w_sclk_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_miso     <= 1'b0;
      r_tx_rd_en <= 1'b0;
      r_rx_wr_en <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_end_pend <= 1'b0;
    end else if (!spe) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_miso     <= 1'b0;
      r_tx_rd_en <= 1'b0;
      r_rx_wr_en <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_end_pend <= 1'b0;
    end else begin
      r_tx_rd_en <= 1'b0;
      r_rx_wr_en <= 1'b0;
      if (w_ss_rise) r_word_cnt <= '0;
      case (r_state)
        IDLE: begin
          r_miso     <= 1'b0;
          r_end_pend <= 1'b0;
          if (w_ss_fall) r_state <= LOAD;
        end
        LOAD: begin
          if (w_ss_rise) begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
          end else begin
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
            if (tx_empty) begin
              r_tx_sh    <= FILL;
              r_miso     <= FILL[DATA_W-1];
              r_underrun <= 1'b1;
            end else begin
              r_tx_sh    <= tx_data;
              r_miso     <= tx_data[DATA_W-1];
              r_tx_rd_en <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (w_sample) begin
            r_rx_sh   <= {r_rx_sh[DATA_W-2:0], r_mosi_sync};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          // the trailing shift edge of the previous word arrives with bit_cnt==0 and is ignored
          if (w_shift && (r_bit_cnt != '0)) begin
            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
            r_miso  <= r_tx_sh[DATA_W-2];
          end
          if (w_sample && (r_bit_cnt == LAST_BIT)) begin
            r_state    <= DONE;
            r_end_pend <= w_ss_rise;
          end else if (w_ss_rise) begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
          end
        end
        DONE: begin
          if (rx_full) begin
            r_overrun <= 1'b1;
          end else begin
            r_rx_data  <= r_rx_sh;
            r_rx_wr_en <= 1'b1;
          end
          if (r_end_pend || w_ss_rise) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_miso     <= 1'b0;
            r_end_pend <= 1'b0;
          end else begin
            r_state <= LOAD;
            if (r_word_cnt != WORDS_MAX) r_word_cnt <= r_word_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso     = r_miso;
  assign tx_rd_en = r_tx_rd_en;
  assign rx_wr_en = r_rx_wr_en;
  assign rx_data  = r_rx_data;
  assign spif     = (r_word_cnt == WORDS_MAX);
  assign overrun  = r_overrun;
  assign underrun = r_underrun;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_spi_target_ctrl.sv
// Directed bench for spi_target_ctrl: mode-0 words driven on sclk/mosi with
// hand-computed expectations for miso, FIFO strobes and status flags.
module tb_spi_target_ctrl;

  logic       clk = 1'b0;
  logic       reset, spe, sclk, ss_n, mosi;
  logic       miso, tx_empty, tx_rd_en, rx_wr_en, rx_full;
  logic       spif, overrun, underrun, busy;
  logic [7:0] tx_data, rx_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_tx = 0;
  int n_rx = 0;
  int tx_at_rx = 0;
  int tx0, rx0;
  logic [7:0] mi;

  spi_target_ctrl #(.DATA_W(8), .BLOCK_WORDS(4), .FILL(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .spe      (spe),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_empty (tx_empty),
    .tx_rd_en (tx_rd_en),
    .rx_data  (rx_data),
    .rx_wr_en (rx_wr_en),
    .rx_full  (rx_full),
    .spif     (spif),
    .overrun  (overrun),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_rd_en) n_tx <= n_tx + 1;
    if (rx_wr_en) begin
      n_rx     <= n_rx + 1;
      tx_at_rx <= n_tx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sclk half period is 4 clk; miso is captured just before each rising edge
  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    clks(4);
    m = miso;
    sclk = 1'b1;
    clks(4);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] mo, output logic [7:0] mo_seen);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      send_bit(mo[i], m);
      mo_seen[i] = m;
    end
  endtask

  initial begin
    logic m;
    reset = 1'b1; spe = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_empty = 1'b0; rx_full = 1'b0;
    clks(3);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", 32'({spif, overrun, underrun}), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    reset = 1'b0;
    clks(2);
    spe = 1'b1;
    clks(2);

    // single word: A5 out, 3C in
    tx_data = 8'hA5; tx0 = n_tx; rx0 = n_rx;
    ss_n = 1'b0; clks(4);
    send_word(8'h3C, mi);
    clks(4);
    check("w1_miso", 32'(mi), 32'hA5);
    check("w1_rx_data", 32'(rx_data), 32'h3C);
    check("w1_rx_cnt", 32'(n_rx - rx0), 32'd1);
    check("w1_tx_cnt", 32'(tx_at_rx - tx0), 32'd1);
    check("w1_busy", 32'(busy), 32'h1);
    ss_n = 1'b1; clks(6);
    check("w1_idle_busy", 32'(busy), 32'h0);
    check("w1_idle_miso", 32'(miso), 32'h0);

    // four-word block sets spif
    tx_data = 8'h5A; tx0 = n_tx; rx0 = n_rx;
    ss_n = 1'b0; clks(4);
    for (int w = 1; w <= 4; w++) begin
      send_word(8'(w), mi);
      clks(4);
      check("blk_rx_data", 32'(rx_data), 32'(w));
      check("blk_miso", 32'(mi), 32'h5A);
      check("blk_spif", 32'(spif), (w == 4) ? 32'h1 : 32'h0);
    end
    check("blk_rx_cnt", 32'(n_rx - rx0), 32'd4);
    check("blk_tx_cnt", 32'(tx_at_rx - tx0), 32'd4);
    ss_n = 1'b1; clks(6);
    check("blk_spif_clr", 32'(spif), 32'h0);

    // tx underrun sends FILL
    tx_empty = 1'b1; tx0 = n_tx;
    ss_n = 1'b0; clks(4);
    send_word(8'h00, mi);
    clks(4);
    check("ur_miso", 32'(mi), 32'hFF);
    check("ur_flag", 32'(underrun), 32'h1);
    check("ur_tx_cnt", 32'(n_tx - tx0), 32'd0);
    check("ur_no_ovr", 32'(overrun), 32'h0);
    ss_n = 1'b1; clks(6);
    tx_empty = 1'b0;

    // rx overrun drops word; flag sticky until spe=0
    rx_full = 1'b1; rx0 = n_rx;
    ss_n = 1'b0; clks(4);
    send_word(8'h55, mi);
    clks(4);
    check("ovr_rx_cnt", 32'(n_rx - rx0), 32'd0);
    check("ovr_flag", 32'(overrun), 32'h1);
    rx_full = 1'b0;
    ss_n = 1'b1; clks(6);
    check("ovr_sticky", 32'(overrun), 32'h1);
    check("ur_sticky", 32'(underrun), 32'h1);
    spe = 1'b0; clks(2);
    check("spe_ovr_clr", 32'(overrun), 32'h0);
    check("spe_ur_clr", 32'(underrun), 32'h0);
    check("spe_busy", 32'(busy), 32'h0);
    spe = 1'b1; clks(2);

    // aborted partial word, then a clean frame
    tx_data = 8'h3C; rx0 = n_rx;
    ss_n = 1'b0; clks(4);
    for (int i = 0; i < 5; i++) send_bit(1'b1, m);
    check("abort_busy_pre", 32'(busy), 32'h1);
    ss_n = 1'b1; clks(4);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rx_cnt", 32'(n_rx - rx0), 32'd0);
    clks(4);
    rx0 = n_rx;
    ss_n = 1'b0; clks(4);
    send_word(8'h96, mi);
    clks(4);
    check("post_rx_data", 32'(rx_data), 32'h96);
    check("post_miso", 32'(mi), 32'h3C);
    check("post_rx_cnt", 32'(n_rx - rx0), 32'd1);
    ss_n = 1'b1; clks(6);

    // reset in SHIFT while underrun and miso are high
    tx_empty = 1'b1; rx0 = n_rx;
    ss_n = 1'b0; clks(4);
    for (int i = 0; i < 3; i++) send_bit(1'b0, m);
    check("pre_rst_miso", 32'(miso), 32'h1);
    check("pre_rst_ur", 32'(underrun), 32'h1);
    reset = 1'b1; ss_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outs", 32'({miso, tx_rd_en, rx_wr_en, spif, overrun, underrun, busy}), 32'h0);
    check("mid_rst_rx_data", 32'(rx_data), 32'h0);
    @(negedge clk);
    reset = 1'b0; tx_empty = 1'b0;
    clks(4);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_rx_cnt", 32'(n_rx - rx0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
